brent_kung_pipe_adder: RTL and testbench



---
 rtl/brent_kung_pipe_adder_if.sv | 30 +++
 rtl/brent_kung_pipe_adder.sv | 164 ++++++++++++++++
 tb/tb_brent_kung_pipe_adder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/brent_kung_pipe_adder_if.sv
`default_nettype none
//==============================================================================
// Module   : brent_kung_pipe_adder_if
// Brief    : operand/result handshake bundle for the pipelined Brent-Kung adder
// Revision : 1.0
//==============================================================================
interface brent_kung_pipe_adder_if #(
    parameter int WIDTH = 12
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   inputs;
    logic                 cin;
    logic                 sub;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH:0]       outs;
    logic                 ovf;

    modport master (
        output in_valid, inputs, cin, sub, out_ready,
        input  in_ready, out_valid, outs, ovf
    );

    modport slave (
        input  in_valid, inputs, cin, sub, out_ready,
        output in_ready, out_valid, outs, ovf
    );
endinterface
`default_nettype wire

// File: rtl/brent_kung_pipe_adder.sv
`default_nettype none
//==============================================================================
// Module   : brent_kung_pipe_adder
// Brief    : pipelined Brent-Kung prefix adder/subtractor, valid/ready handshake
// Revision : 1.0
//==============================================================================
module brent_kung_pipe_adder #(
    parameter int WIDTH       = 12,
    parameter int PIPE_STAGES = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    brent_kung_pipe_adder_if.slave bus
);
    localparam int c_LOG   = $clog2(WIDTH);
    localparam int c_NP    = 1 << c_LOG;
    localparam int c_N_LVL = 2 * c_LOG - 1;

    // True when a pipeline register sits after prefix level lvl (level 0 = bit g/p).
    function automatic bit f_reg_after(input int lvl);
        bit hit;
        hit = 1'b0;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            if ((k * c_N_LVL) / PIPE_STAGES == lvl) hit = 1'b1;
        end
        return hit;
    endfunction

    logic                             w_advance;
    logic [WIDTH-1:0]                 w_a;
    logic [WIDTH-1:0]                 w_b;
    logic [WIDTH-1:0]                 w_bx;
    logic [WIDTH-1:0]                 w_p0;
    logic                             w_c0;
    logic [c_N_LVL:0][c_NP-1:0]       w_lvl_g;
    logic [c_N_LVL:0][c_NP-1:0]       w_lvl_p;
    logic [c_N_LVL:0][c_NP-1:0]       w_src_g;
    logic [c_N_LVL:0][c_NP-1:0]       w_src_p;
    logic [c_N_LVL:0][WIDTH-1:0]      w_lvl_ps;
    logic [c_N_LVL:0][WIDTH-1:0]      w_src_ps;
    logic [c_N_LVL:0]                 w_lvl_c0;
    logic [c_N_LVL:0]                 w_src_c0;
    logic [c_N_LVL:0]                 w_lvl_v;
    logic [c_N_LVL:0]                 w_src_v;
    logic [WIDTH:0]                   w_carry;
    logic [WIDTH-1:0]                 w_sum;
    logic                             w_unused;
    logic                             r_out_valid;
    logic [WIDTH:0]                   r_outs;
    logic                             r_ovf;

    assign w_advance     = ~r_out_valid | bus.out_ready;
    assign bus.in_ready  = w_advance;
    assign bus.out_valid = r_out_valid;
    assign bus.outs      = r_outs;
    assign bus.ovf       = r_ovf;

    for (genvar i = 0; i < WIDTH; i++) begin : g_split
        assign w_a[i] = bus.inputs[2*i];
        assign w_b[i] = bus.inputs[2*i+1];
    end

    assign w_bx = bus.sub ? ~w_b : w_b;
    assign w_c0 = bus.sub | bus.cin;
    assign w_p0 = w_a ^ w_bx;

    // Level 0: per-bit generate/propagate; carry-in folded into g[0]; pad bits zero.
    for (genvar i = 0; i < c_NP; i++) begin : g_lvl0
        if (i == 0) begin : g_bit0
            assign w_lvl_g[0][i] = (w_a[i] & w_bx[i]) | (w_p0[i] & w_c0);
            assign w_lvl_p[0][i] = w_p0[i];
        end else if (i < WIDTH) begin : g_bit
            assign w_lvl_g[0][i] = w_a[i] & w_bx[i];
            assign w_lvl_p[0][i] = w_p0[i];
        end else begin : g_pad
            assign w_lvl_g[0][i] = 1'b0;
            assign w_lvl_p[0][i] = 1'b0;
        end
    end
    assign w_lvl_ps[0] = w_p0;
    assign w_lvl_c0[0] = w_c0;
    assign w_lvl_v[0]  = bus.in_valid;

    // Levels 1..c_LOG are the up-sweep, the remainder the down-sweep.
    for (genvar j = 1; j <= c_N_LVL; j++) begin : g_lvl
        localparam bit c_UP = (j <= c_LOG);
        localparam int c_D  = c_UP ? (1 << (j - 1)) : (1 << (2 * c_LOG - j - 1));
        for (genvar i = 0; i < c_NP; i++) begin : g_node
            localparam bit c_COMB = c_UP ? (((i + 1) % (2 * c_D)) == 0)
                                         : ((((i + 1) % (2 * c_D)) == c_D) && (i >= 2 * c_D));
            if (c_COMB) begin : g_op
                assign w_lvl_g[j][i] = w_src_g[j-1][i] | (w_src_p[j-1][i] & w_src_g[j-1][i-c_D]);
                assign w_lvl_p[j][i] = w_src_p[j-1][i] & w_src_p[j-1][i-c_D];
            end else begin : g_pass
                assign w_lvl_g[j][i] = w_src_g[j-1][i];
                assign w_lvl_p[j][i] = w_src_p[j-1][i];
            end
        end
        assign w_lvl_ps[j] = w_src_ps[j-1];
        assign w_lvl_c0[j] = w_src_c0[j-1];
        assign w_lvl_v[j]  = w_src_v[j-1];
    end

    for (genvar j = 0; j <= c_N_LVL; j++) begin : g_bnd
        if (f_reg_after(j)) begin : g_reg
            logic [c_NP-1:0]  r_g;
            logic [c_NP-1:0]  r_p;
            logic [WIDTH-1:0] r_ps;
            logic             r_c0;
            logic             r_v;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v  <= 1'b0;
                    r_g  <= '0;
                    r_p  <= '0;
                    r_ps <= '0;
                    r_c0 <= 1'b0;
                end else if (w_advance) begin
                    r_v <= w_lvl_v[j];
                    if (w_lvl_v[j]) begin
                        r_g  <= w_lvl_g[j];
                        r_p  <= w_lvl_p[j];
                        r_ps <= w_lvl_ps[j];
                        r_c0 <= w_lvl_c0[j];
                    end
                end
            end

            assign w_src_g[j]  = r_g;
            assign w_src_p[j]  = r_p;
            assign w_src_ps[j] = r_ps;
            assign w_src_c0[j] = r_c0;
            assign w_src_v[j]  = r_v;
        end else begin : g_wire
            assign w_src_g[j]  = w_lvl_g[j];
            assign w_src_p[j]  = w_lvl_p[j];
            assign w_src_ps[j] = w_lvl_ps[j];
            assign w_src_c0[j] = w_lvl_c0[j];
            assign w_src_v[j]  = w_lvl_v[j];
        end
    end

    // Group generate of bits [i:0] is the carry into bit i+1.
    assign w_carry  = {w_src_g[c_N_LVL][WIDTH-1:0], w_src_c0[c_N_LVL]};
    assign w_sum    = w_src_ps[c_N_LVL] ^ w_carry[WIDTH-1:0];
    assign w_unused = ^{w_src_p[c_N_LVL], w_src_g[c_N_LVL]};

    // Data only loads with a valid result so outputs never pick up idle-bus garbage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_outs      <= '0;
            r_ovf       <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= w_src_v[c_N_LVL];
            if (w_src_v[c_N_LVL]) begin
                r_outs <= {w_carry[WIDTH], w_sum};
                r_ovf  <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_brent_kung_pipe_adder.sv
`default_nettype none
//==============================================================================
// Module   : tb_brent_kung_pipe_adder
// Brief    : vector table, directed stall/reset sequences and multi-config random
// Revision : 1.0
//==============================================================================
module tb_brent_kung_pipe_adder;
    localparam int NCFG = 6;
    localparam int NOPS = 4000;

    function automatic int cfg_w(input int g);
        case (g)
            0: return 2;
            1: return 8;
            2: return 12;
            3: return 12;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_p(input int g);
        case (g)
            0: return 2;
            1: return 1;
            2: return 3;
            3: return 8;
            4: return 10;
            default: return 3;
        endcase
    endfunction

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic        cin;
        logic        sub;
        logic [12:0] outs;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   nout   = 0;
    logic [33:0] mq [$];
    vec_t vecs [11];

    always #5 clk = ~clk;

    brent_kung_pipe_adder_if #(.WIDTH(12)) bus ();
    brent_kung_pipe_adder #(.WIDTH(12), .PIPE_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [NCFG-1:0] rv, rcin, rsub, rordy, rrdy, rovld, rovf;
    logic [63:0]     rin   [NCFG];
    logic [32:0]     routs [NCFG];
    logic [33:0]     rq    [NCFG][$];

    for (genvar g = 0; g < NCFG; g++) begin : g_rnd
        localparam int W = cfg_w(g);
        brent_kung_pipe_adder_if #(.WIDTH(W)) rbus ();
        brent_kung_pipe_adder #(.WIDTH(W), .PIPE_STAGES(cfg_p(g))) rdut (
            .clk (clk),
            .rst (rst),
            .bus (rbus)
        );
        assign rbus.in_valid  = rv[g];
        assign rbus.inputs    = rin[g][2*W-1:0];
        assign rbus.cin       = rcin[g];
        assign rbus.sub       = rsub[g];
        assign rbus.out_ready = rordy[g];
        assign rrdy[g]        = rbus.in_ready;
        assign rovld[g]       = rbus.out_valid;
        assign rovf[g]        = rbus.ovf;
        assign routs[g]       = 33'(rbus.outs);
    end

    // Reference: plain integer arithmetic; [33]=signed overflow, [32:0]=carry+sum.
    function automatic logic [33:0] ref_op(input int w, input logic [63:0] ops,
                                           input logic cin, input logic sub);
        longint unsigned a, b, full;
        longint          sa, sb, res, lim;
        logic [33:0]     r;
        a = 0;
        b = 0;
        for (int i = 0; i < w; i++) begin
            a[i] = ops[2*i];
            b[i] = ops[2*i+1];
        end
        full = sub ? (a + (64'd1 << w) - b) : (a + b + 64'(cin));
        sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        res  = sub ? (sa - sb) : (sa + sb + longint'(cin));
        lim  = longint'(1) << (w - 1);
        r[33]   = (res >= lim) || (res < -lim);
        r[32:0] = full[32:0];
        return r;
    endfunction

    function automatic logic [23:0] ilv12(input logic [11:0] a, input logic [11:0] b);
        logic [23:0] r;
        for (int i = 0; i < 12; i++) begin
            r[2*i]   = a[i];
            r[2*i+1] = b[i];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // One main-DUT cycle: drive at negedge, observe transfers before the next posedge.
    task automatic main_cycle(input logic v, input logic [23:0] ops, input logic cin,
                              input logic sub, input logic ordy, output logic acc);
        logic [33:0] e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.inputs    = ops;
        bus.cin       = cin;
        bus.sub       = sub;
        bus.out_ready = ordy;
        #1;
        acc = v && bus.in_ready;
        if (acc) mq.push_back(ref_op(12, 64'(ops), cin, sub));
        if (bus.out_valid && ordy) begin
            check("out_expected", 64'(mq.size() != 0), 64'd1);
            if (mq.size() != 0) begin
                e = mq.pop_front();
                check("seq_outs", 64'(bus.outs), 64'(e[12:0]));
                check("seq_ovf", 64'(bus.ovf), 64'(e[33]));
                nout++;
            end
        end
    endtask

    initial begin
        int          lat;
        int          sent;
        int          sent_r [NCFG];
        int          got_r  [NCFG];
        logic        acc;
        logic [12:0] held;
        logic [33:0] e;
        logic [63:0] mask;
        bit          all_done;

        vecs[0]  = '{12'hFFF, 12'h001, 1'b0, 1'b0, 13'h1000, 1'b0};
        vecs[1]  = '{12'h000, 12'h001, 1'b0, 1'b1, 13'h0FFF, 1'b0};
        vecs[2]  = '{12'h800, 12'h001, 1'b0, 1'b1, 13'h17FF, 1'b1};
        vecs[3]  = '{12'h7FF, 12'h000, 1'b1, 1'b0, 13'h0800, 1'b1};
        vecs[4]  = '{12'hFFF, 12'hFFF, 1'b1, 1'b0, 13'h1FFF, 1'b0};
        vecs[5]  = '{12'h123, 12'h456, 1'b0, 1'b0, 13'h0579, 1'b0};
        vecs[6]  = '{12'h555, 12'h555, 1'b0, 1'b1, 13'h1000, 1'b0};
        vecs[7]  = '{12'h010, 12'h001, 1'b1, 1'b1, 13'h100F, 1'b0};
        vecs[8]  = '{12'h400, 12'h400, 1'b0, 1'b0, 13'h0800, 1'b1};
        vecs[9]  = '{12'h7FF, 12'hFFF, 1'b0, 1'b1, 13'h0800, 1'b1};
        vecs[10] = '{12'hAAA, 12'h555, 1'b1, 1'b0, 13'h1000, 1'b0};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.inputs = '0; bus.cin = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b0;
        rv = '0; rcin = '0; rsub = '0; rordy = '0;
        for (int g = 0; g < NCFG; g++) rin[g] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_outs", 64'(bus.outs), 64'd0);
        check("reset_ovf", 64'(bus.ovf), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);

        // Table vectors, one at a time: latency and result.
        foreach (vecs[k]) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.inputs    = ilv12(vecs[k].a, vecs[k].b);
            bus.cin       = vecs[k].cin;
            bus.sub       = vecs[k].sub;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            lat = 1;
            while (!bus.out_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check($sformatf("vec%0d_latency", k), 64'(lat), 64'd2);
            check($sformatf("vec%0d_outs", k), 64'(bus.outs), 64'(vecs[k].outs));
            check($sformatf("vec%0d_ovf", k), 64'(bus.ovf), 64'(vecs[k].ovf));
        end
        @(posedge clk);

        // Six ops back-to-back with a three-cycle downstream stall in the middle.
        nout = 0;
        sent = 0;
        held = '0;
        for (int c = 0; c < 40 && nout < 6; c++) begin
            logic ordy;
            ordy = !(c >= 3 && c < 6);
            main_cycle(sent < 6, 24'($urandom), 1'($urandom), 1'($urandom), ordy, acc);
            if (acc) sent++;
            if (c < 3) check("b2b_accept", 64'(acc), 64'd1);
            if (!ordy && bus.out_valid) begin
                check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                if (c > 3) check("stall_outs_stable", 64'(bus.outs), 64'(held));
                held = bus.outs;
            end
        end
        check("stall_count", 64'(nout), 64'd6);
        check("stall_drain", 64'(mq.size()), 64'd0);

        // Reset with two ops in flight: neither may ever emerge.
        main_cycle(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0, acc);
        main_cycle(1'b1, 24'($urandom), 1'b1, 1'b1, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_flush_valid", 64'(bus.out_valid), 64'd0);
        mq.delete();
        nout = 0;
        for (int c = 0; c < 6; c++) begin
            main_cycle(1'b0, 24'd0, 1'b0, 1'b0, 1'b1, acc);
            check("rst_idle", 64'(bus.out_valid), 64'd0);
        end
        sent = 0;
        for (int c = 0; c < 10 && nout < 1; c++) begin
            main_cycle(sent == 0, ilv12(12'h3A5, 12'h0C3), 1'b1, 1'b0, 1'b1, acc);
            if (acc) sent++;
        end
        check("rst_recover_count", 64'(nout), 64'd1);

        // Random traffic on all other configurations in lockstep.
        for (int g = 0; g < NCFG; g++) begin
            sent_r[g] = 0;
            got_r[g]  = 0;
        end
        all_done = 1'b0;
        for (int cyc = 0; cyc < 30000 && !all_done; cyc++) begin
            @(negedge clk);
            for (int g = 0; g < NCFG; g++) begin
                mask     = (cfg_w(g) == 32) ? '1 : ((64'd1 << (2 * cfg_w(g))) - 64'd1);
                rv[g]    = (sent_r[g] < NOPS) && ($urandom % 4 != 0);
                rin[g]   = {$urandom, $urandom} & mask;
                rcin[g]  = 1'($urandom);
                rsub[g]  = 1'($urandom);
                rordy[g] = ($urandom % 4 != 0);
            end
            #1;
            all_done = 1'b1;
            for (int g = 0; g < NCFG; g++) begin
                if (rv[g] && rrdy[g]) begin
                    rq[g].push_back(ref_op(cfg_w(g), rin[g], rcin[g], rsub[g]));
                    sent_r[g]++;
                end
                if (rovld[g] && rordy[g]) begin
                    check($sformatf("rnd%0d_expected", g), 64'(rq[g].size() != 0), 64'd1);
                    if (rq[g].size() != 0) begin
                        e = rq[g].pop_front();
                        check($sformatf("rnd%0d_outs", g), 64'(routs[g]), 64'(e[32:0]));
                        check($sformatf("rnd%0d_ovf", g), 64'(rovf[g]), 64'(e[33]));
                        got_r[g]++;
                    end
                end
                if (got_r[g] < NOPS) all_done = 1'b0;
            end
        end
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("rnd%0d_count", g), 64'(got_r[g]), 64'(NOPS));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
